// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizes for the data-memory port arbiter.
package dmem_arb_pkg;
   localparam int DEF_DATA_W   = 32;
   localparam int DEF_ADDR_W   = 9;
   localparam int DEF_MAX_WAIT = 4;

   typedef enum logic {C_IDLE, C_RDRET} cpu_state_e;
   typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_LDR} owner_e;
endpackage

// File: rtl/arb_starve_cnt.sv
// Counts consecutive refused loader cycles; raises ldr_pri once the loader has waited MAX_WAIT.
module arb_starve_cnt #(
   parameter int MAX_WAIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic ldr_req,
   input  logic ldr_gnt,
   output logic ldr_pri
);
   localparam int CW = $clog2(MAX_WAIT + 1);

   logic [CW-1:0] starve_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         starve_cnt <= '0;
      else if (!ldr_req || ldr_gnt)
         starve_cnt <= '0;
      else if (starve_cnt != CW'(MAX_WAIT))
         starve_cnt <= starve_cnt + 1'b1;
   end

   assign ldr_pri = (starve_cnt == CW'(MAX_WAIT));
endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one synchronous-read data memory between the MEM stage and a loader/debug port.
// CPU wins the issue slot unless the loader has starved for MAX_WAIT cycles.
module dmem_port_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int MAX_WAIT = DEF_MAX_WAIT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_rd,
   input  logic              cpu_wr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wr_data,
   output logic [DATA_W-1:0] cpu_rd_data,
   output logic              cpu_stall,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic              ldr_gnt,
   output logic              ldr_rvalid,
   output logic [DATA_W-1:0] ldr_rdata,
   output logic              mem_wr,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   input  logic [DATA_W-1:0] mem_rd_data
);
   cpu_state_e state, state_nxt;
   owner_e     rsp_owner, owner_nxt;
   logic       ldr_pri, cpu_go, cpu_load, ldr_issue, cpu_issue;

   arb_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve (
      .clk     (clk),
      .reset   (reset),
      .ldr_req (ldr_req),
      .ldr_gnt (ldr_gnt),
      .ldr_pri (ldr_pri)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= C_IDLE;
         rsp_owner <= OWN_NONE;
      end else begin
         state     <= state_nxt;
         rsp_owner <= owner_nxt;
      end
   end

   // Issue logic is gated by reset so no strobe leaks out while it is held low.
   always_comb begin
      cpu_load    = cpu_rd && !cpu_wr;
      cpu_go      = reset && (cpu_rd || cpu_wr) && (state == C_IDLE);
      ldr_issue   = reset && ldr_req && (!cpu_go || ldr_pri);
      cpu_issue   = cpu_go && !ldr_issue;
      state_nxt   = (state == C_RDRET) ? C_IDLE : state;
      owner_nxt   = OWN_NONE;
      mem_wr      = 1'b0;
      mem_rd      = 1'b0;
      mem_addr    = '0;
      mem_wr_data = '0;
      if (ldr_issue) begin
         mem_wr      = ldr_we;
         mem_rd      = !ldr_we;
         mem_addr    = ldr_addr;
         mem_wr_data = ldr_we ? ldr_wdata : '0;
         owner_nxt   = ldr_we ? OWN_NONE : OWN_LDR;
      end else if (cpu_issue) begin
         mem_wr      = cpu_wr;
         mem_rd      = cpu_load;
         mem_addr    = cpu_addr;
         mem_wr_data = cpu_wr ? cpu_wr_data : '0;
         if (cpu_load) begin
            owner_nxt = OWN_CPU;
            state_nxt = C_RDRET;
         end
      end
      ldr_gnt   = ldr_issue;
      cpu_stall = cpu_go && (ldr_issue || cpu_load);
   end

   assign cpu_rd_data = (rsp_owner == OWN_CPU) ? mem_rd_data : '0;
   assign ldr_rvalid  = (rsp_owner == OWN_LDR);
   assign ldr_rdata   = ldr_rvalid ? mem_rd_data : '0;

   a_rdwr_excl: assert property (@(posedge clk) disable iff (!reset) !(cpu_rd && cpu_wr));
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: rule-level model checked every cycle plus literal pins.
module tb_dmem_port_arbiter;
   localparam int DATA_W = 32, ADDR_W = 9, MAX_WAIT = 4;

   logic clk = 1'b0, reset = 1'b0;
   logic cpu_rd = 0, cpu_wr = 0, ldr_req = 0, ldr_we = 0;
   logic [ADDR_W-1:0] cpu_addr = '0, ldr_addr = '0, mem_addr;
   logic [DATA_W-1:0] cpu_wr_data = '0, ldr_wdata = '0, cpu_rd_data, ldr_rdata, mem_wr_data;
   logic [DATA_W-1:0] mem_rd_data = '0;
   logic cpu_stall, ldr_gnt, ldr_rvalid, mem_wr, mem_rd;

   int n_chk = 0, n_fail = 0;

   dmem_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset),
      .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data),
      .cpu_rd_data(cpu_rd_data), .cpu_stall(cpu_stall),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
      .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
      .mem_rd_data(mem_rd_data)
   );

   always #5 clk = ~clk;

   // Memory attached to the DUT.
   logic [DATA_W-1:0] bmem [512];
   always @(posedge clk) begin
      if (mem_wr) bmem[mem_addr] <= mem_wr_data;
      if (mem_rd) mem_rd_data <= bmem[mem_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: what the rules say the outputs must be, plus its own memory image.
   logic [DATA_W-1:0] ref_mem [512];
   int unsigned m_refused = 0, n_refused = 0;
   int          m_own = 0, n_own = 0;      // 0 none, 1 cpu, 2 loader
   bit          m_wait = 0, n_wait = 0;    // cpu load already issued, data due now
   logic [DATA_W-1:0] m_data = '0, n_data = '0, n_wdata = '0;
   logic [ADDR_W-1:0] n_waddr = '0;
   bit          n_wr = 0;

   always @(negedge clk) begin
      bit go, lw, ci, e_wr, e_rd, e_stall;
      logic [ADDR_W-1:0] e_addr;
      logic [DATA_W-1:0] e_wd, e_crd, e_lrd;
      bit e_rv;
      if (!reset) begin
         e_wr = 0; e_rd = 0; e_stall = 0; lw = 0; e_addr = '0; e_wd = '0;
         e_crd = '0; e_lrd = '0; e_rv = 0;
         n_wait = 0; n_refused = 0; n_own = 0; n_data = '0; n_wr = 0;
      end else begin
         go      = (cpu_rd || cpu_wr) && !m_wait;
         lw      = ldr_req && (!go || m_refused >= MAX_WAIT);
         ci      = go && !lw;
         e_wr    = lw ? ldr_we  : (ci && cpu_wr);
         e_rd    = lw ? !ldr_we : (ci && cpu_rd && !cpu_wr);
         e_addr  = lw ? ldr_addr : (ci ? cpu_addr : '0);
         e_wd    = e_wr ? (lw ? ldr_wdata : cpu_wr_data) : '0;
         e_stall = go && (lw || (cpu_rd && !cpu_wr));
         e_crd   = (m_own == 1) ? m_data : '0;
         e_rv    = (m_own == 2);
         e_lrd   = e_rv ? m_data : '0;
         n_wait    = ci && e_rd;
         n_refused = (ldr_req && !lw) ? ((m_refused + 1 > MAX_WAIT) ? MAX_WAIT : m_refused + 1) : 0;
         n_own     = e_rd ? (lw ? 2 : 1) : 0;
         n_data    = e_rd ? ref_mem[e_addr] : '0;
         n_wr      = e_wr;
         n_waddr   = e_addr;
         n_wdata   = e_wd;
      end
      chk("mdl_cpu_stall", cpu_stall, e_stall);
      chk("mdl_ldr_gnt", ldr_gnt, lw);
      chk("mdl_mem_wr", mem_wr, e_wr);
      chk("mdl_mem_rd", mem_rd, e_rd);
      chk("mdl_mem_addr", mem_addr, e_addr);
      chk("mdl_mem_wr_data", mem_wr_data, e_wd);
      chk("mdl_cpu_rd_data", cpu_rd_data, e_crd);
      chk("mdl_ldr_rvalid", ldr_rvalid, e_rv);
      chk("mdl_ldr_rdata", ldr_rdata, e_lrd);
   end

   always @(posedge clk) begin
      m_wait    <= n_wait;
      m_refused <= n_refused;
      m_own     <= n_own;
      m_data    <= n_data;
      if (n_wr) ref_mem[n_waddr] <= n_wdata;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cpu_rd = 0; cpu_wr = 0; ldr_req = 0; ldr_we = 0;
   endtask

   initial begin
      for (int i = 0; i < 512; i++) begin
         bmem[i] = '0;
         ref_mem[i] = '0;
      end
      @(negedge clk);
      chk("rst_stall", cpu_stall, 0);
      chk("rst_rvalid", ldr_rvalid, 0);
      tick(); tick();
      reset = 1;

      // 1: CPU store, single cycle, no stall
      cpu_wr = 1; cpu_addr = 9'h010; cpu_wr_data = 32'hDEADBEEF;
      @(negedge clk);
      chk("t1_mem_wr", mem_wr, 1);
      chk("t1_stall", cpu_stall, 0);
      tick(); idle();
      @(negedge clk);
      chk("t1_stall_after", cpu_stall, 0);
      chk("t1_mem_wr_after", mem_wr, 0);

      // 2: CPU load of the stored word
      tick(); cpu_rd = 1; cpu_addr = 9'h010;
      @(negedge clk);
      chk("t2_stall1", cpu_stall, 1);
      chk("t2_mem_rd", mem_rd, 1);
      tick();
      @(negedge clk);
      chk("t2_stall0", cpu_stall, 0);
      chk("t2_data", cpu_rd_data, 32'hDEADBEEF);
      tick(); idle();

      // 3: loader write with CPU idle
      ldr_req = 1; ldr_we = 1; ldr_addr = 9'h020; ldr_wdata = 32'h1234;
      @(negedge clk);
      chk("t3_gnt", ldr_gnt, 1);
      chk("t3_mem_wr", mem_wr, 1);
      chk("t3_addr", mem_addr, 9'h020);
      tick(); idle();

      // 4: back-to-back CPU stores starve the loader until the 5th request cycle
      ldr_req = 1; ldr_we = 1; ldr_addr = 9'h030; ldr_wdata = 32'hA5A5A5A5;
      for (int i = 0; i < 5; i++) begin
         cpu_wr = 1; cpu_addr = 9'(9'h040 + i); cpu_wr_data = 32'(i + 100);
         @(negedge clk);
         chk("t4_gnt", ldr_gnt, (i == 4));
         chk("t4_stall", cpu_stall, (i == 4));
         if (i < 4) tick();
      end
      tick(); ldr_req = 0;
      @(negedge clk);
      chk("t4_retry_wr", mem_wr, 1);
      chk("t4_retry_addr", mem_addr, 9'h044);
      tick(); idle();

      // loader drops its request before a grant: the wait count restarts
      for (int i = 0; i < 8; i++) begin
         cpu_wr = 1; cpu_addr = 9'(9'h050 + i); cpu_wr_data = 32'(i);
         ldr_req = (i != 2); ldr_we = 1; ldr_addr = 9'h060; ldr_wdata = 32'h77;
         @(negedge clk);
         chk("drop_gnt", ldr_gnt, (i == 7));
         if (i != 7) tick();
      end
      tick(); idle();
      @(negedge clk);
      tick();

      // 5: CPU load, loader read issued in the return cycle, no cross-routing
      cpu_rd = 1; cpu_addr = 9'h010;
      tick();
      ldr_req = 1; ldr_we = 0; ldr_addr = 9'h020;
      @(negedge clk);
      chk("t5_gnt", ldr_gnt, 1);
      chk("t5_mem_rd", mem_rd, 1);
      chk("t5_cpu_data", cpu_rd_data, 32'hDEADBEEF);
      chk("t5_rvalid_early", ldr_rvalid, 0);
      tick(); idle();
      @(negedge clk);
      chk("t5_rvalid", ldr_rvalid, 1);
      chk("t5_ldr_data", ldr_rdata, 32'h1234);
      chk("t5_cpu_data_clr", cpu_rd_data, 0);
      tick();

      // 6: reset asserted while a CPU load is returning
      cpu_rd = 1; cpu_addr = 9'h020;
      tick();
      reset = 0;
      @(negedge clk);
      chk("t6_rst_mem_rd", mem_rd, 0);
      chk("t6_rst_stall", cpu_stall, 0);
      chk("t6_rst_cpu_data", cpu_rd_data, 0);
      tick(); idle(); reset = 1;
      @(negedge clk);
      chk("t6_rvalid", ldr_rvalid, 0);
      chk("t6_stall", cpu_stall, 0);
      tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
